freq_meas_ctrl: RTL
===================

Name: freq_meas_ctrl

Overview:
- Measurement sequencer for the edge-counting frequency datapath: opens, closes and clears the counter's gate window and latches the count.
- Four selectable gate lengths with optional auto-ranging. Single-shot or continuous mode, with start/busy/valid handshake toward the readout/display logic.
- Sits between the control/UI logic and the edge counter. It owns the counter's clear and enable; it never counts edges itself.

Parameters:
- GATE_CYC_0, 200_000, gate length in sys_clk cycles for range 0 (1 ms @ 200 MHz)
- GATE_CYC_1, 2_000_000, gate length for range 1 (10 ms)
- GATE_CYC_2, 20_000_000, gate length for range 2 (100 ms)
- GATE_CYC_3, 200_000_000, gate length for range 3 (1 s)
- SETTLE_CYC, 4, cycles waited after gate close before latching; must be >= counter edge-detect pipeline depth + 1
- LO_THRESH, 1000, auto-range: count below this steps to a longer gate
- HI_THRESH, 100_000_000, auto-range: count at or above this steps to a shorter gate

Ports:
- sys_clk  in  1  system clock
- rst  in  1  reset, synchronous, active-high
- start  in  1  one-cycle request to begin a measurement; honoured only in IDLE
- abort  in  1  terminate any measurement, return to IDLE
- cont  in  1  continuous mode: after DONE, restart automatically
- auto_en  in  1  1 = auto-ranging, 0 = use range_sel
- range_sel  in  2  manual range, sampled on start (and on each continuous restart)
- cnt_val  in  32  current count from the datapath
- cnt_clr  out  1  one-cycle synchronous clear to the counter
- cnt_en  out  1  gate: counter accumulates edges while 1
- busy  out  1  1 in every state except IDLE
- meas_cnt  out  32  latched count of last completed measurement
- meas_range  out  2  range used for meas_cnt
- meas_valid  out  1  one-cycle pulse when meas_cnt/meas_range update
- cur_range  out  2  range of the current or next measurement

Behaviour:
- Reset: all outputs 0, cur_range = 0, state IDLE, gate counter 0. Reset mid-measurement behaves identically; no meas_valid is issued.
- States: IDLE, CLEAR, GATE, SETTLE, LATCH.
- IDLE: on start=1 go to CLEAR. cur_range <= range_sel if auto_en=0, else unchanged.
- CLEAR: cnt_clr=1 for exactly this one cycle; load gate counter with GATE_CYC[cur_range]-1; go to GATE.
- GATE: cnt_en=1. Decrement the gate counter each cycle; at 0 go to SETTLE. cnt_en is high for exactly GATE_CYC[cur_range] consecutive cycles.
- SETTLE: cnt_en=0 for SETTLE_CYC cycles, then LATCH.
- LATCH, one cycle:
  - meas_cnt <= cnt_val, meas_range <= cur_range, meas_valid pulses on the following cycle.
  - If auto_en: cnt_val < LO_THRESH and cur_range < 3 → cur_range+1; else cnt_val >= HI_THRESH and cur_range > 0 → cur_range-1; else unchanged. Saturates at 0 and 3; no wrap.
  - Next state: CLEAR if cont=1 (re-sampling range_sel when auto_en=0), else IDLE.
- Latency: start → first cnt_en cycle = 2 cycles. Last cnt_en cycle → meas_valid = SETTLE_CYC+2 cycles.
- busy=1 from the cycle after start is accepted until the state returns to IDLE.
- start while busy: ignored, not queued.
- abort: highest priority after rst. From any state, next cycle is IDLE with cnt_en=0. No meas_valid; meas_cnt, meas_range and cur_range are unchanged. abort and start in the same cycle: abort wins, start is dropped.
- cont deasserted mid-measurement: the current measurement completes, then IDLE.
- auto_en or range_sel changes mid-measurement: take effect only at the next CLEAR / LATCH decision.
- Gate counter is 32-bit; GATE_CYC_n must lie in 1..2^32-1.

Test Plan:
- Small parameters: GATE_CYC_0..3 = 10/100/1000/10000, SETTLE_CYC=4, LO=8, HI=500.
- Manual single shot: auto_en=0, range_sel=1, start pulse, model cnt_val=37 → cnt_clr 1 cycle, cnt_en high exactly 100 cycles, meas_valid once with meas_cnt=37, meas_range=1; busy drops; no further cnt_clr.
- Auto-range up: auto_en=1, cont=1, from reset, cnt_val = 0.5 × gate cycles → range 0 gives 5 (<8) → cur_range 1; range 1 gives 50 → stays 1; meas_range sequence 0,1,1.
- Auto-range down and saturation: cnt_val forced to 600 at range 3 → steps 3→2; held at 600 → stepping stops at 0; LO path at range 3 stays 3.
- Abort mid-gate: abort at gate cycle 50 of range 1 → cnt_en 0 next cycle, IDLE, no meas_valid, meas_cnt holds previous value; start ignored while busy, abort+start same cycle → stays IDLE.
- Reset mid-SETTLE: rst=1 one cycle → all outputs 0, cur_range 0, no meas_valid; a new start afterward runs a clean range-0 measurement.
- Continuous stop: cont=1 for 3 measurements, then cont=0 during GATE → exactly one more meas_valid, then IDLE with busy=0.

Source files
------------

// File: rtl/freq_meas_ctrl_if.sv
// Control/readout bundle between the UI logic, the edge counter and the measurement sequencer.
// master: the side that requests measurements and supplies the count; slave: the sequencer.
interface freq_meas_ctrl_if;
    logic        start;
    logic        abort;
    logic        cont;
    logic        auto_en;
    logic [1:0]  range_sel;
    logic [31:0] cnt_val;
    logic        cnt_clr;
    logic        cnt_en;
    logic        busy;
    logic [31:0] meas_cnt;
    logic [1:0]  meas_range;
    logic        meas_valid;
    logic [1:0]  cur_range;

    modport master (
        output start, abort, cont, auto_en, range_sel, cnt_val,
        input  cnt_clr, cnt_en, busy, meas_cnt, meas_range, meas_valid, cur_range
    );

    modport slave (
        input  start, abort, cont, auto_en, range_sel, cnt_val,
        output cnt_clr, cnt_en, busy, meas_cnt, meas_range, meas_valid, cur_range
    );
endinterface

// File: rtl/freq_meas_ctrl.sv
// Measurement sequencer for the edge-counting frequency datapath: clears the counter, opens the
// gate for the selected range, waits for the counter pipeline to settle, then latches the count.
module freq_meas_ctrl #(
    parameter int unsigned GATE_CYC_0 = 200_000,
    parameter int unsigned GATE_CYC_1 = 2_000_000,
    parameter int unsigned GATE_CYC_2 = 20_000_000,
    parameter int unsigned GATE_CYC_3 = 200_000_000,
    parameter int unsigned SETTLE_CYC = 4,
    parameter int unsigned LO_THRESH  = 1000,
    parameter int unsigned HI_THRESH  = 100_000_000
) (
    input logic             sys_clk,
    input logic             rst,
    freq_meas_ctrl_if.slave bus
);

    localparam logic [31:0] GateM1Rng0 = 32'(GATE_CYC_0 - 1);
    localparam logic [31:0] GateM1Rng1 = 32'(GATE_CYC_1 - 1);
    localparam logic [31:0] GateM1Rng2 = 32'(GATE_CYC_2 - 1);
    localparam logic [31:0] GateM1Rng3 = 32'(GATE_CYC_3 - 1);
    localparam logic [31:0] SettleM1   = 32'(SETTLE_CYC - 1);
    localparam logic [31:0] LoThresh   = 32'(LO_THRESH);
    localparam logic [31:0] HiThresh   = 32'(HI_THRESH);

    typedef enum logic [2:0] {
        StIdle,
        StClear,
        StGate,
        StSettle,
        StLatch
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] gate_cnt_q, gate_cnt_d;
    logic [1:0]  cur_range_q, cur_range_d;
    logic [1:0]  meas_range_q, meas_range_d;
    logic [31:0] meas_cnt_q, meas_cnt_d;
    logic        meas_valid_q, meas_valid_d;
    logic [31:0] gate_len_m1;
    logic [1:0]  auto_range;

    always_comb begin
        gate_len_m1 = GateM1Rng0;
        case (cur_range_q)
            2'd0:    gate_len_m1 = GateM1Rng0;
            2'd1:    gate_len_m1 = GateM1Rng1;
            2'd2:    gate_len_m1 = GateM1Rng2;
            default: gate_len_m1 = GateM1Rng3;
        endcase
    end

    // Step one range per measurement, saturating at both ends.
    always_comb begin
        auto_range = cur_range_q;
        if ((bus.cnt_val < LoThresh) && (cur_range_q != 2'd3)) begin
            auto_range = cur_range_q + 2'd1;
        end else if ((bus.cnt_val >= HiThresh) && (cur_range_q != 2'd0)) begin
            auto_range = cur_range_q - 2'd1;
        end
    end

    always_comb begin
        state_d      = state_q;
        gate_cnt_d   = gate_cnt_q;
        cur_range_d  = cur_range_q;
        meas_range_d = meas_range_q;
        meas_cnt_d   = meas_cnt_q;
        meas_valid_d = 1'b0;

        if (bus.abort) begin
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (bus.start) begin
                        state_d = StClear;
                        if (!bus.auto_en) begin
                            cur_range_d = bus.range_sel;
                        end
                    end
                end
                StClear: begin
                    gate_cnt_d = gate_len_m1;
                    state_d    = StGate;
                end
                StGate: begin
                    if (gate_cnt_q == 32'd0) begin
                        gate_cnt_d = SettleM1;
                        state_d    = StSettle;
                    end else begin
                        gate_cnt_d = gate_cnt_q - 32'd1;
                    end
                end
                StSettle: begin
                    if (gate_cnt_q == 32'd0) begin
                        state_d = StLatch;
                    end else begin
                        gate_cnt_d = gate_cnt_q - 32'd1;
                    end
                end
                StLatch: begin
                    meas_cnt_d   = bus.cnt_val;
                    meas_range_d = cur_range_q;
                    meas_valid_d = 1'b1;
                    if (bus.auto_en) begin
                        cur_range_d = auto_range;
                    end else if (bus.cont) begin
                        cur_range_d = bus.range_sel;
                    end
                    state_d = bus.cont ? StClear : StIdle;
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            state_q      <= StIdle;
            gate_cnt_q   <= 32'd0;
            cur_range_q  <= 2'd0;
            meas_range_q <= 2'd0;
            meas_cnt_q   <= 32'd0;
            meas_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            gate_cnt_q   <= gate_cnt_d;
            cur_range_q  <= cur_range_d;
            meas_range_q <= meas_range_d;
            meas_cnt_q   <= meas_cnt_d;
            meas_valid_q <= meas_valid_d;
        end
    end

    assign bus.cnt_clr    = (state_q == StClear);
    assign bus.cnt_en     = (state_q == StGate);
    assign bus.busy       = (state_q != StIdle);
    assign bus.meas_cnt   = meas_cnt_q;
    assign bus.meas_range = meas_range_q;
    assign bus.meas_valid = meas_valid_q;
    assign bus.cur_range  = cur_range_q;

endmodule
